// File: rtl/cache_axi_pkg.sv
// Shared definitions for the cache-to-AXI read path.
// Contents: read-type encodings, bridge read IDs, the default size used for
// instruction reads, and the arbiter state type.
package cache_axi_pkg;
  localparam logic [2:0] RD_TYPE_WORD = 3'b010;
  localparam logic [2:0] RD_TYPE_LINE = 3'b100;
  localparam logic       RID_INST     = 1'b0;
  localparam logic       RID_DATA     = 1'b1;
  localparam logic [2:0] INST_RD_SIZE = 3'd2;

  typedef enum logic {ARB_IDLE, ARB_SEND} rr_state;
endpackage

// File: rtl/wr_line_tracker.sv
// Tracks the line tags of dcache writes that have been accepted by the bridge
// and are still waiting for their B response.
// Ports:
//   clk, reset      clock, async active-high reset
//   push_en/tag     a write was accepted; record its line tag
//   pop_en          B response; retire the oldest write
//   cmp_a/cmp_b     line tags of the two read requesters
//   hit_a/hit_b     the matching tag is held in a valid entry
//   full            every entry is in use
module wr_line_tracker #(
  parameter int TAG_W = 28,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_en,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop_en,
  input  logic [TAG_W-1:0] cmp_a,
  input  logic [TAG_W-1:0] cmp_b,
  output logic             hit_a,
  output logic             hit_b,
  output logic             full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [TAG_W-1:0] tags [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  assign full = (count == CNT_W'(DEPTH));
  // Illegal pushes/pops are dropped so the FIFO can never corrupt itself.
  assign push = push_en && !full;
  assign pop  = pop_en && (count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) tags[i] <= '0;
      valid  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
      // A legal push never lands on the entry being popped: that would need a full FIFO.
      if (push) begin
        tags[wr_ptr]  <= push_tag;
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Compare uses registered entries only: a push shows up next cycle and a
  // same-cycle pop still blocks for the current cycle.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (tags[i] == cmp_a)) hit_a = 1'b1;
      if (valid[i] && (tags[i] == cmp_b)) hit_b = 1'b1;
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push_en && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(pop_en && (count == '0)));
endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter putting icache/dcache read misses onto the single
// bridge read-request port, one read in flight per requester, holding back
// reads whose line matches an un-acknowledged dcache write.
// Ports:
//   clk, reset                 clock, async active-high reset
//   inst_rd_*                  icache request (req/type/addr in, rdy out)
//   data_rd_*                  dcache request (req/type/addr/size in, rdy out)
//   bus_rd_*                   request to bridge (req/id/type/addr/size out, rdy in)
//   inst_ret_valid/data_ret_valid  read data returned; requester free again
//   wr_fire/wr_addr/wr_ok      write accepted / its B response
//   wr_block                   write tracker full, bridge must stall writes
//   hazard_stall               a pending read is held back by a write match
module axi_rd_arbiter
  import cache_axi_pkg::*;
#(
  parameter int LINE_OFF_W = 4,
  parameter int WB_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_rd_req,
  input  logic [2:0]  inst_rd_type,
  input  logic [31:0] inst_rd_addr,
  output logic        inst_rd_rdy,
  input  logic        data_rd_req,
  input  logic [2:0]  data_rd_type,
  input  logic [31:0] data_rd_addr,
  input  logic [2:0]  data_rd_size,
  output logic        data_rd_rdy,
  output logic        bus_rd_req,
  output logic        bus_rd_id,
  output logic [2:0]  bus_rd_type,
  output logic [31:0] bus_rd_addr,
  output logic [2:0]  bus_rd_size,
  input  logic        bus_rd_rdy,
  input  logic        inst_ret_valid,
  input  logic        data_ret_valid,
  input  logic        wr_fire,
  input  logic [31:0] wr_addr,
  input  logic        wr_ok,
  output logic        wr_block,
  output logic        hazard_stall
);
  localparam int TAG_W = 32 - LINE_OFF_W;

  rr_state    state;
  rr_state    next_state;
  logic       rr_ptr;
  logic [1:0] outstanding;
  logic [1:0] outstanding_nxt;
  logic [1:0] req;
  logic [1:0] hit;
  logic [1:0] eligible;
  logic       grant_any;
  logic       grant_id;
  logic       accept;
  logic       wr_addr_unused;

  assign wr_addr_unused = ^wr_addr[LINE_OFF_W-1:0];

  wr_line_tracker #(.TAG_W(TAG_W), .DEPTH(WB_DEPTH)) u_tracker (
    .clk      (clk),
    .reset    (reset),
    .push_en  (wr_fire),
    .push_tag (wr_addr[31:LINE_OFF_W]),
    .pop_en   (wr_ok),
    .cmp_a    (inst_rd_addr[31:LINE_OFF_W]),
    .cmp_b    (data_rd_addr[31:LINE_OFF_W]),
    .hit_a    (hit[0]),
    .hit_b    (hit[1]),
    .full     (wr_block)
  );

  assign req          = {data_rd_req, inst_rd_req};
  assign eligible     = req & ~outstanding & ~hit;
  assign hazard_stall = |(req & ~outstanding & hit);
  assign accept       = (state == ARB_SEND) && bus_rd_rdy;

  always_comb begin
    next_state  = state;
    inst_rd_rdy = 1'b0;
    data_rd_rdy = 1'b0;
    bus_rd_req  = 1'b0;
    grant_any   = 1'b0;
    grant_id    = RID_INST;
    case (state)
      ARB_IDLE: begin
        if (|eligible) begin
          grant_any = 1'b1;
          // rr_ptr names the requester that wins a tie.
          if (eligible[1] && ((rr_ptr == RID_DATA) || !eligible[0])) grant_id = RID_DATA;
          else                                                      grant_id = RID_INST;
          inst_rd_rdy = (grant_id == RID_INST);
          data_rd_rdy = (grant_id == RID_DATA);
          next_state  = ARB_SEND;
        end
      end
      ARB_SEND: begin
        bus_rd_req = 1'b1;
        if (bus_rd_rdy) next_state = ARB_IDLE;
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  // Set wins over clear: a return cannot belong to a read accepted this cycle.
  always_comb begin
    outstanding_nxt = outstanding & ~{data_ret_valid, inst_ret_valid};
    if (accept) outstanding_nxt[bus_rd_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ARB_IDLE;
      rr_ptr      <= RID_DATA;
      outstanding <= '0;
    end else begin
      state       <= next_state;
      outstanding <= outstanding_nxt;
      if (accept) rr_ptr <= ~bus_rd_id;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_rd_id   <= RID_INST;
      bus_rd_type <= '0;
      bus_rd_addr <= '0;
      bus_rd_size <= '0;
    end else if (grant_any) begin
      bus_rd_id <= grant_id;
      if (grant_id == RID_DATA) begin
        bus_rd_type <= data_rd_type;
        bus_rd_addr <= data_rd_addr;
        bus_rd_size <= data_rd_size;
      end else begin
        bus_rd_type <= inst_rd_type;
        bus_rd_addr <= inst_rd_addr;
        bus_rd_size <= INST_RD_SIZE;
      end
    end
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        inst_rd_req, data_rd_req, bus_rd_rdy;
  logic [2:0]  inst_rd_type, data_rd_type, data_rd_size;
  logic [31:0] inst_rd_addr, data_rd_addr, wr_addr;
  logic        inst_ret_valid, data_ret_valid, wr_fire, wr_ok;
  logic        inst_rd_rdy, data_rd_rdy, bus_rd_req, bus_rd_id, wr_block, hazard_stall;
  logic [2:0]  bus_rd_type, bus_rd_size;
  logic [31:0] bus_rd_addr;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] WORD = 3'b010;
  localparam logic [2:0] LINE = 3'b100;

  always #5 clk = ~clk;

  axi_rd_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_rd_req(inst_rd_req), .inst_rd_type(inst_rd_type), .inst_rd_addr(inst_rd_addr),
    .inst_rd_rdy(inst_rd_rdy),
    .data_rd_req(data_rd_req), .data_rd_type(data_rd_type), .data_rd_addr(data_rd_addr),
    .data_rd_size(data_rd_size), .data_rd_rdy(data_rd_rdy),
    .bus_rd_req(bus_rd_req), .bus_rd_id(bus_rd_id), .bus_rd_type(bus_rd_type),
    .bus_rd_addr(bus_rd_addr), .bus_rd_size(bus_rd_size), .bus_rd_rdy(bus_rd_rdy),
    .inst_ret_valid(inst_ret_valid), .data_ret_valid(data_ret_valid),
    .wr_fire(wr_fire), .wr_addr(wr_addr), .wr_ok(wr_ok),
    .wr_block(wr_block), .hazard_stall(hazard_stall)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what the bridge should be doing, kept as a pending
  // transaction, per-requester busy flags and a queue of un-acked write lines.
  logic        m_busy, m_id, m_pref_data, m_out_i, m_out_d;
  logic [2:0]  m_type, m_size;
  logic [31:0] m_addr;
  logic [27:0] wq[$];

  function automatic bit line_pending(input logic [31:0] a);
    foreach (wq[k]) if (wq[k] == a[31:4]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_id = 0; m_pref_data = 1; m_out_i = 0; m_out_d = 0;
    m_type = 0; m_size = 0; m_addr = 0;
    wq.delete();
  endtask

  initial model_reset();

  always begin : compare
    logic hi, hd, ei, ed, e_ir, e_dr, e_hz;
    logic n_busy, n_id, n_pref, n_oi, n_od, do_pop, do_push;
    logic [2:0] n_type, n_size;
    logic [31:0] n_addr;
    logic [27:0] push_tag;
    @(negedge clk);
    if (reset) begin
      model_reset();
      chk("rst_bus_req", bus_rd_req, 0);
      chk("rst_inst_rdy", inst_rd_rdy, 0);
      chk("rst_data_rdy", data_rd_rdy, 0);
      chk("rst_wr_block", wr_block, 0);
      chk("rst_hazard", hazard_stall, 0);
      chk("rst_bus_addr", bus_rd_addr, 0);
    end else begin
      hi = line_pending(inst_rd_addr);
      hd = line_pending(data_rd_addr);
      ei = inst_rd_req && !m_out_i && !hi;
      ed = data_rd_req && !m_out_d && !hd;
      e_hz = (inst_rd_req && !m_out_i && hi) || (data_rd_req && !m_out_d && hd);
      e_ir = 0; e_dr = 0;
      n_busy = m_busy; n_id = m_id; n_pref = m_pref_data; n_oi = m_out_i; n_od = m_out_d;
      n_type = m_type; n_size = m_size; n_addr = m_addr;
      if (!m_busy) begin
        if (ed && (m_pref_data || !ei)) begin
          e_dr = 1; n_busy = 1; n_id = 1;
          n_type = data_rd_type; n_addr = data_rd_addr; n_size = data_rd_size;
        end else if (ei) begin
          e_ir = 1; n_busy = 1; n_id = 0;
          n_type = inst_rd_type; n_addr = inst_rd_addr; n_size = 3'd2;
        end
      end
      if (inst_ret_valid) n_oi = 0;
      if (data_ret_valid) n_od = 0;
      if (m_busy && bus_rd_rdy) begin
        n_busy = 0;
        n_pref = !m_id;
        if (m_id) n_od = 1; else n_oi = 1;
      end
      do_pop   = wr_ok && (wq.size() > 0);
      do_push  = wr_fire && (wq.size() < 2);
      push_tag = wr_addr[31:4];

      chk("inst_rd_rdy", inst_rd_rdy, e_ir);
      chk("data_rd_rdy", data_rd_rdy, e_dr);
      chk("bus_rd_req", bus_rd_req, m_busy);
      chk("wr_block", wr_block, wq.size() == 2);
      chk("hazard_stall", hazard_stall, e_hz);
      if (m_busy) begin
        chk("bus_rd_id", bus_rd_id, m_id);
        chk("bus_rd_type", bus_rd_type, m_type);
        chk("bus_rd_addr", bus_rd_addr, m_addr);
        chk("bus_rd_size", bus_rd_size, m_size);
      end
      @(posedge clk);
      if (!reset) begin
        m_busy = n_busy; m_id = n_id; m_pref_data = n_pref; m_out_i = n_oi; m_out_d = n_od;
        m_type = n_type; m_size = n_size; m_addr = n_addr;
        if (do_pop) void'(wq.pop_front());
        if (do_push) wq.push_back(push_tag);
      end
    end
  end

  task automatic nxt(); @(posedge clk); #1; endtask
  task automatic neg(); @(negedge clk); endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1;
    inst_rd_req = 0; inst_rd_type = LINE; inst_rd_addr = 0;
    data_rd_req = 0; data_rd_type = LINE; data_rd_addr = 0; data_rd_size = 0;
    bus_rd_rdy = 0; inst_ret_valid = 0; data_ret_valid = 0;
    wr_fire = 0; wr_addr = 0; wr_ok = 0;
    neg();
    chk("lit_reset_bus_req", bus_rd_req, 0);
    nxt(); reset = 0;

    // 1: simultaneous requests, data wins first
    inst_rd_req = 1; inst_rd_addr = 32'h0000_1000;
    data_rd_req = 1; data_rd_addr = 32'h0000_2000; data_rd_size = 3'd2;
    neg(); chk("t1_data_rdy", data_rd_rdy, 1); chk("t1_inst_rdy", inst_rd_rdy, 0);
    nxt(); data_rd_req = 0; bus_rd_rdy = 1;
    neg(); chk("t1_bus_id", bus_rd_id, 1); chk("t1_bus_addr", bus_rd_addr, 32'h2000);
    nxt(); bus_rd_rdy = 0;
    neg(); chk("t1_inst_rdy_late", inst_rd_rdy, 1);
    nxt(); inst_rd_req = 0; bus_rd_rdy = 1;
    neg(); chk("t1_bus_id_inst", bus_rd_id, 0); chk("t1_bus_size_inst", bus_rd_size, 2);
    nxt(); bus_rd_rdy = 0;

    // 2: inst already in flight
    inst_rd_req = 1; inst_rd_addr = 32'h0000_1040;
    for (int i = 0; i < 3; i++) begin
      neg(); chk("t2_inst_blocked", inst_rd_rdy, 0); nxt();
    end
    inst_ret_valid = 1;
    neg(); chk("t2_ret_cycle", inst_rd_rdy, 0);
    nxt(); inst_ret_valid = 0;
    neg(); chk("t2_inst_grant", inst_rd_rdy, 1);
    nxt(); inst_rd_req = 0;

    // 5: bridge stalls 5 cycles, latched request must hold
    data_rd_req = 1; data_rd_addr = 32'h0000_3000; data_rd_size = 3'd3; data_ret_valid = 1;
    for (int i = 0; i < 5; i++) begin
      neg();
      chk("t5_bus_req", bus_rd_req, 1);
      chk("t5_bus_addr", bus_rd_addr, 32'h1040);
      chk("t5_data_rdy", data_rd_rdy, 0);
      nxt(); data_ret_valid = 0;
    end
    bus_rd_rdy = 1;
    neg(); chk("t5_accept_no_rdy", data_rd_rdy, 0);
    nxt(); bus_rd_rdy = 0;
    neg(); chk("t5_data_grant", data_rd_rdy, 1);
    nxt(); data_rd_req = 0; bus_rd_rdy = 1;
    neg(); chk("t5_bus_size", bus_rd_size, 3);
    nxt(); bus_rd_rdy = 0; inst_ret_valid = 1; data_ret_valid = 1;
    nxt(); inst_ret_valid = 0; data_ret_valid = 0;

    // 3: RAW hazard on a pending write line
    wr_fire = 1; wr_addr = 32'h8000_1234;
    nxt(); wr_fire = 0;
    data_rd_req = 1; data_rd_type = WORD; data_rd_addr = 32'h8000_1230; data_rd_size = 3'd2;
    for (int i = 0; i < 2; i++) begin
      neg(); chk("t3_hazard", hazard_stall, 1); chk("t3_no_rdy", data_rd_rdy, 0); nxt();
    end
    wr_ok = 1;
    neg(); chk("t3_pop_cycle_rdy", data_rd_rdy, 0);
    nxt(); wr_ok = 0;
    neg(); chk("t3_grant", data_rd_rdy, 1); chk("t3_hazard_clear", hazard_stall, 0);
    nxt(); data_rd_req = 0; bus_rd_rdy = 1;
    nxt(); bus_rd_rdy = 0; data_ret_valid = 1;
    nxt(); data_ret_valid = 0;

    // 4: tracker full, oldest retired first
    wr_fire = 1; wr_addr = 32'h0000_0100;
    nxt(); wr_addr = 32'h0000_0200;
    nxt(); wr_fire = 0;
    inst_rd_req = 1; inst_rd_type = LINE; inst_rd_addr = 32'h0000_0104;
    data_rd_req = 1; data_rd_type = LINE; data_rd_addr = 32'h0000_0208; data_rd_size = 3'd2;
    neg(); chk("t4_wr_block", wr_block, 1); chk("t4_hazard", hazard_stall, 1);
    nxt(); wr_ok = 1;
    neg(); chk("t4_pop_cycle", inst_rd_rdy, 0);
    nxt(); wr_ok = 0;
    neg();
    chk("t4_inst_104", inst_rd_rdy, 1); chk("t4_data_208", data_rd_rdy, 0);
    chk("t4_unblock", wr_block, 0);
    nxt(); inst_rd_req = 0; bus_rd_rdy = 1;
    nxt(); bus_rd_rdy = 0;
    wr_fire = 1; wr_addr = 32'h0000_0300; wr_ok = 1;
    neg(); chk("t4_still_stalled", data_rd_rdy, 0);
    nxt(); wr_fire = 0; wr_ok = 0;
    neg(); chk("t4_data_grant", data_rd_rdy, 1);
    nxt(); data_rd_req = 0;

    // 6: reset mid-SEND with inst in flight and a write tracked
    neg(); chk("t6_in_send", bus_rd_req, 1);
    nxt(); reset = 1;
    #1 chk("t6_async_drop", bus_rd_req, 0);
    neg();
    nxt(); reset = 0;
    inst_rd_req = 1; inst_rd_addr = 32'h0000_0304;
    neg(); chk("t6_inst_free", inst_rd_rdy, 1); chk("t6_tracker_empty", hazard_stall, 0);
    nxt(); inst_rd_req = 0; bus_rd_rdy = 1;
    neg(); chk("t6_bus_addr", bus_rd_addr, 32'h0304);
    nxt(); bus_rd_rdy = 0;
    nxt(); nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
